cla32_acc: RTL and testbench

CLA32_ACC -- requirements
Module: cla32_acc

---
 rtl/cla32_acc.sv | 120 ++++++++++++
 tb/tb_cla32_acc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla32_acc.sv
// Accumulates N carry-lookahead adder results ({co,s}) into a 37-bit registered total,
// with a ready/valid handshake on both sides and a count of carry-out terms per group.
module cla32_acc #(
   parameter int N = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] s,
   input  logic        co,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        clr,
   output logic [36:0] sum_out,
   output logic [4:0]  carry_cnt,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam logic [4:0] N_CNT = 5'(N);

   typedef enum logic {
      ACC  = 1'b0,
      DONE = 1'b1
   } state_t;

   state_t      state_r, state_s;
   logic [36:0] acc_r, acc_s;
   logic [4:0]  cnt_r, cnt_s;
   logic [4:0]  carry_s;
   logic [36:0] sum_s;
   logic        out_valid_s;
   logic        in_ready_s;
   logic [36:0] term_s;
   logic [36:0] total_s;
   logic        accept_s;

   // Next-state and next-output computation; clr overrides every other event.
   always_comb begin
      state_s     = state_r;
      acc_s       = acc_r;
      cnt_s       = cnt_r;
      carry_s     = carry_cnt;
      sum_s       = sum_out;
      out_valid_s = out_valid;
      term_s      = {4'd0, co, s};
      total_s     = acc_r + term_s;
      accept_s    = in_valid & in_ready;

      if (clr) begin
         state_s     = ACC;
         acc_s       = 37'd0;
         cnt_s       = 5'd0;
         carry_s     = 5'd0;
         out_valid_s = 1'b0;
      end else begin
         case (state_r)
            ACC: begin
               if (accept_s) begin
                  acc_s   = total_s;
                  cnt_s   = cnt_r + 5'd1;
                  carry_s = carry_cnt + {4'd0, co};
                  if ((cnt_r + 5'd1) == N_CNT) begin
                     sum_s       = total_s;
                     out_valid_s = 1'b1;
                     state_s     = DONE;
                  end else begin
                     state_s = ACC;
                  end
               end else begin
                  state_s = ACC;
               end
            end
            DONE: begin
               // sum_out is deliberately kept; only the next completion replaces it.
               if (out_ready) begin
                  acc_s       = 37'd0;
                  cnt_s       = 5'd0;
                  carry_s     = 5'd0;
                  out_valid_s = 1'b0;
                  state_s     = ACC;
               end else begin
                  state_s = DONE;
               end
            end
            default: begin
               state_s     = ACC;
               acc_s       = 37'd0;
               cnt_s       = 5'd0;
               carry_s     = 5'd0;
               out_valid_s = 1'b0;
            end
         endcase
      end

      // Registered ready follows the state being entered, so it rises on the first edge after reset.
      in_ready_s = (state_s == ACC);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ACC;
         acc_r     <= 37'd0;
         cnt_r     <= 5'd0;
         carry_cnt <= 5'd0;
         sum_out   <= 37'd0;
         out_valid <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         state_r   <= state_s;
         acc_r     <= acc_s;
         cnt_r     <= cnt_s;
         carry_cnt <= carry_s;
         sum_out   <= sum_s;
         out_valid <= out_valid_s;
         in_ready  <= in_ready_s;
      end
   end

endmodule

// File: tb/tb_cla32_acc.sv
// Randomized self-checking bench for cla32_acc; the reference model keeps the accepted
// terms of the current group in a queue and sums them when the group is complete.
module tb_cla32_acc;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] s = 32'd0;
   logic        co = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        clr = 1'b0;
   logic [36:0] sum_out;
   logic [4:0]  carry_cnt;
   logic        out_valid;
   logic        out_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [32:0] grp[$];
   logic [36:0] m_sum = 37'd0;
   logic        m_valid = 1'b0;
   logic        m_ready = 1'b0;

   cla32_acc #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .s(s), .co(co), .in_valid(in_valid),
      .in_ready(in_ready), .clr(clr), .sum_out(sum_out), .carry_cnt(carry_cnt),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] m_carry();
      logic [4:0] c = 5'd0;
      foreach (grp[i]) c += {4'd0, grp[i][32]};
      return c;
   endfunction

   function automatic logic [36:0] m_total();
      logic [36:0] t = 37'd0;
      foreach (grp[i]) t += {4'd0, grp[i]};
      return t;
   endfunction

   task automatic model_reset();
      grp.delete();
      m_sum = 37'd0;
      m_valid = 1'b0;
      m_ready = 1'b0;
   endtask

   // Drive one cycle of inputs, advance the model at the edge, return #1 after it.
   task automatic cycle(input logic v, input logic [31:0] sv, input logic cv,
                        input logic c, input logic r);
      in_valid = v; s = sv; co = cv; clr = c; out_ready = r;
      @(posedge clk);
      if (c) begin
         grp.delete();
         m_valid = 1'b0;
      end else if (m_valid) begin
         if (r) begin
            grp.delete();
            m_valid = 1'b0;
         end
      end else if (m_ready && v) begin
         grp.push_back({cv, sv});
         if (grp.size() == N) begin
            m_sum = m_total();
            m_valid = 1'b1;
         end
      end
      m_ready = !m_valid;
      #1;
      in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      checks++;
      if (sum_out !== 37'd0 || carry_cnt !== 5'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: sum=%h cc=%0d ov=%b ir=%b, want all zero", sum_out, carry_cnt, out_valid, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready_before_edge: got %b want 0", in_ready);
      end
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready_after_edge: got %b want 1", in_ready);
      end
   endtask

   task automatic test_basic();
      for (int i = 1; i <= 4; i++) begin
         cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
         checks++;
         if (out_valid !== (i == 4)) begin
            errors++;
            $display("FAIL basic_valid term %0d: got %b want %b", i, out_valid, (i == 4));
         end
      end
      checks++;
      if (sum_out !== 37'd10 || carry_cnt !== 5'd0) begin
         errors++;
         $display("FAIL basic_sum: sum=%0d cc=%0d, want 10 and 0", sum_out, carry_cnt);
      end
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_drain: ov=%b ir=%b, want 0 and 1", out_valid, in_ready);
      end
   endtask

   task automatic test_max();
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || sum_out !== 37'h7_FFFF_FFFC || carry_cnt !== 5'd4) begin
         errors++;
         $display("FAIL max_sum: ov=%b sum=%h cc=%0d, want 1 7fffffffc 4", out_valid, sum_out, carry_cnt);
      end
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_backpressure();
      logic [36:0] held;
      for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'($urandom_range(1)), 1'b0, 1'b0);
      held = m_sum;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum_out !== held || carry_cnt !== m_carry()) begin
            errors++;
            $display("FAIL bp_hold cycle %0d: ir=%b ov=%b sum=%h cc=%0d, want 0 1 %h %0d",
                     i, in_ready, out_valid, sum_out, carry_cnt, held, m_carry());
         end
      end
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum_out !== held) begin
         errors++;
         $display("FAIL bp_release: ov=%b ir=%b sum=%h, want 0 1 %h", out_valid, in_ready, sum_out, held);
      end
      for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'($urandom_range(1)), 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || sum_out !== m_sum || carry_cnt !== m_carry()) begin
         errors++;
         $display("FAIL bp_next_group: ov=%b sum=%h cc=%0d, want 1 %h %0d", out_valid, sum_out, carry_cnt, m_sum, m_carry());
      end
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_clr();
      logic [36:0] prev;
      prev = sum_out;
      cycle(1'b1, 32'd7, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 32'd7, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'd9, 1'b1, 1'b1, 1'b0);
      checks++;
      if (carry_cnt !== 5'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || sum_out !== prev) begin
         errors++;
         $display("FAIL clr_clear: cc=%0d ov=%b ir=%b sum=%h, want 0 0 1 %h", carry_cnt, out_valid, in_ready, sum_out, prev);
      end
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || sum_out !== 37'd20) begin
         errors++;
         $display("FAIL clr_sum: ov=%b sum=%0d, want 1 20", out_valid, sum_out);
      end
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_gaps();
      for (int i = 1; i <= 4; i++) begin
         cycle(1'b1, 32'(100 * i), 1'b0, 1'b0, 1'b0);
         checks++;
         if (out_valid !== (i == 4)) begin
            errors++;
            $display("FAIL gaps_valid term %0d: got %b want %b", i, out_valid, (i == 4));
         end
         if (i < 4) begin
            for (int g = 0; g < int'($urandom_range(3, 1)); g++) begin
               cycle(1'b0, $urandom, 1'b1, 1'b0, 1'b1);
               checks++;
               if (out_valid !== 1'b0) begin
                  errors++;
                  $display("FAIL gaps_idle_valid: got %b want 0", out_valid);
               end
            end
         end
      end
      checks++;
      if (sum_out !== 37'd1000) begin
         errors++;
         $display("FAIL gaps_sum: got %0d want 1000", sum_out);
      end
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'd50, 1'b1, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || carry_cnt !== 5'd0 || sum_out !== 37'd0) begin
         errors++;
         $display("FAIL areset_immediate: ov=%b ir=%b cc=%0d sum=%h, want all zero", out_valid, in_ready, carry_cnt, sum_out);
      end
      #2;
      rst_n = 1'b1;
      cycle(1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || sum_out !== 37'd8 || carry_cnt !== 5'd0) begin
         errors++;
         $display("FAIL areset_regroup: ov=%b sum=%0d cc=%0d, want 1 8 0", out_valid, sum_out, carry_cnt);
      end
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(3) != 0), $urandom, 1'($urandom_range(1)),
               1'($urandom_range(31) == 0), 1'($urandom_range(2) == 0));
         checks++;
         if (out_valid !== m_valid || in_ready !== m_ready || carry_cnt !== m_carry() || sum_out !== m_sum) begin
            errors++;
            $display("FAIL random cycle %0d: ov=%b ir=%b cc=%0d sum=%h, want %b %b %0d %h",
                     i, out_valid, in_ready, carry_cnt, sum_out, m_valid, m_ready, m_carry(), m_sum);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max();
      test_backpressure();
      test_clr();
      test_gaps();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
